// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Releases NUM_STAGES downstream reset domains one at a time, in index order.
// After the clk-domain reset request has been low for HOLD_CYCLES, stage 0 is
// released; each released stage must raise its ready acknowledge, after which
// a GAP_CYCLES pause is inserted before the next stage is released. Once the
// last stage is acknowledged and its gap has elapsed, done is raised.
//
// Optional feature (macro RESET_SEQUENCER_TIMEOUT_EN):
//   When defined, a stage that fails to acknowledge within TIMEOUT_CYCLES puts
//   the block into a sticky FAULT state: every stage is put back into reset,
//   fault is raised and fault_stage reports the offending index. When the
//   macro is undefined, WAIT_ACK waits indefinitely and fault/fault_stage are
//   tied to 0.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   rst_req      in   active-high reset request, synchronous to clk
//   stage_ack    in   per-stage ready acknowledge (level, synchronous to clk)
//   stage_rst    out  per-stage active-high reset (registered)
//   done         out  all stages released and acknowledged (registered)
//   fault        out  acknowledge timeout occurred (registered)
//   fault_stage  out  index of the stage that timed out (registered)
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int unsigned NUM_STAGES     = 4,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned GAP_CYCLES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 16,
  localparam int unsigned IdxW          = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rst_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  done,
  output logic                  fault,
  output logic [IdxW-1:0]       fault_stage
);

  // ---------------------------------------------------------------------------
  // Parameter legality
  // ---------------------------------------------------------------------------
  localparam int unsigned MaxHg     = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned MaxCycles = (MaxHg > TIMEOUT_CYCLES) ? MaxHg : TIMEOUT_CYCLES;

  if (NUM_STAGES < 1) begin : g_bad_num_stages
    $error("reset_sequencer: NUM_STAGES must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("reset_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap
    $error("reset_sequencer: GAP_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("reset_sequencer: TIMEOUT_CYCLES must be >= 1");
  end
  // Counter must be able to hold every terminal count.
  if (CNT_W == 0 || (CNT_W < 32 && (64'd1 << CNT_W) <= 64'(MaxCycles))) begin : g_bad_cnt_w
    $error("reset_sequencer: 2**CNT_W must exceed max(HOLD, GAP, TIMEOUT) cycles");
  end

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GapLast  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NUM_STAGES - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    StHold,
    StRelease,
    StWaitAck,
    StGap,
    StDone,
    StFault
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [NUM_STAGES-1:0]   stage_rst_q, stage_rst_d;
  logic                    done_q, done_d;

  // Shared decode of the current cycle's conditions.
  logic ack_cur;
  logic hold_last;
  logic gap_last;
  logic last_stage;
  logic timeout_hit;

  always_comb begin
    ack_cur    = stage_ack[idx_q];
    hold_last  = (cnt_q == HoldLast);
    gap_last   = (cnt_q == GapLast);
    last_stage = (idx_q == LastIdx);
  end

`ifdef RESET_SEQUENCER_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);

  // An ack arriving on the terminal cycle wins over the timeout.
  always_comb begin
    timeout_hit = (state_q == StWaitAck) && !ack_cur && (cnt_q == TimeoutLast);
  end
`else
  always_comb begin
    timeout_hit = 1'b0;
  end
`endif

  // ---------------------------------------------------------------------------
  // Process 1: state register (plus counter, index and registered outputs)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHold;
      cnt_q       <= '0;
      idx_q       <= '0;
      stage_rst_q <= '1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stage_rst_q <= stage_rst_d;
      done_q      <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Process 2: next-state, counter and index
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;

    if (rst_req) begin
      // A request restarts everything, including the hold count.
      state_d = StHold;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StHold: begin
          if (hold_last) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = StRelease;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        StRelease: begin
          cnt_d   = '0;
          state_d = StWaitAck;
        end

        StWaitAck: begin
          if (ack_cur) begin
            cnt_d   = '0;
            state_d = StGap;
          end else if (timeout_hit) begin
            cnt_d   = '0;
            state_d = StFault;
          end else begin
`ifdef RESET_SEQUENCER_TIMEOUT_EN
            cnt_d = cnt_q + CNT_W'(1);
`endif
          end
        end

        StGap: begin
          if (gap_last) begin
            cnt_d = '0;
            if (last_stage) begin
              state_d = StDone;
            end else begin
              idx_d   = idx_q + IdxW'(1);
              state_d = StRelease;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        // Sticky until rst_req or rst_n.
        StDone, StFault: begin
          state_d = state_q;
        end

        default: begin
          state_d = StHold;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Process 3: next values of the registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    stage_rst_d = stage_rst_q;
    done_d      = done_q;

    if (rst_req) begin
      stage_rst_d = '1;
      done_d      = 1'b0;
    end else begin
      unique case (state_q)
        StRelease: begin
          stage_rst_d[idx_q] = 1'b0;
        end
        StWaitAck: begin
          // A timed-out stage sends every domain back into reset.
          if (timeout_hit) begin
            stage_rst_d = '1;
          end
        end
        StGap: begin
          if (gap_last && last_stage) begin
            done_d = 1'b1;
          end
        end
        default: begin
          stage_rst_d = stage_rst_q;
        end
      endcase
    end
  end

  assign stage_rst = stage_rst_q;
  assign done      = done_q;

  // ---------------------------------------------------------------------------
  // Fault reporting
  // ---------------------------------------------------------------------------
`ifdef RESET_SEQUENCER_TIMEOUT_EN
  logic            fault_q, fault_d;
  logic [IdxW-1:0] fault_stage_q, fault_stage_d;

  always_comb begin
    fault_d       = fault_q;
    fault_stage_d = fault_stage_q;
    if (rst_req) begin
      fault_d       = 1'b0;
      fault_stage_d = '0;
    end else if (timeout_hit) begin
      fault_d       = 1'b1;
      fault_stage_d = idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q       <= 1'b0;
      fault_stage_q <= '0;
    end else begin
      fault_q       <= fault_d;
      fault_stage_q <= fault_stage_d;
    end
  end

  assign fault       = fault_q;
  assign fault_stage = fault_stage_q;
`else
  assign fault       = 1'b0;
  assign fault_stage = '0;
`endif

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Consumes the clk-domain reset request produced by the reset synchronizer.
- Releases NUM_STAGES downstream reset domains one at a time, in index order 0..NUM_STAGES-1.
- Before releasing the next stage, waits for the current stage's ready acknowledge, then inserts a fixed gap.
- Sits between the reset synchronizer and the per-subsystem reset nets. Reports sequence-complete, and optionally an acknowledge-timeout fault.

Parameters:
- NUM_STAGES, 4: number of sequenced reset outputs; must be >= 1.
- HOLD_CYCLES, 16: cycles rst_req must stay low before stage 0 is released; must be >= 1.
- GAP_CYCLES, 8: cycles between accepting an ack and releasing the next stage; must be >= 1.
- TIMEOUT_CYCLES, 1024: ack wait limit per stage; used only with the optional feature; must be >= 1.
- CNT_W, 16: shared counter width; must satisfy 2^CNT_W > max(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES). Violating any parameter rule is an elaboration error.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rst_req  input  1  active-high reset request, already synchronous to clk (synchronizer output)
- stage_ack  input  NUM_STAGES  per-stage ready, level-sensitive, synchronous to clk
- stage_rst  output  NUM_STAGES  per-stage active-high reset, registered
- done  output  1  all stages released and acknowledged, registered
- fault  output  1  ack timeout occurred, registered
- fault_stage  output  max(1,$clog2(NUM_STAGES))  index of the stage that timed out

Behaviour:
- Reset values (rst_n low, asynchronous):
  - stage_rst = all ones; done = 0; fault = 0; fault_stage = 0.
  - state = HOLD; cnt = 0; idx = 0.
- All outputs come straight from flops; there are no combinational paths from inputs to outputs.
- States: HOLD, RELEASE, WAIT_ACK, GAP, DONE, FAULT.
- HOLD:
  - stage_rst is all ones.
  - cnt increments on each cycle with rst_req = 0.
  - When cnt == HOLD_CYCLES-1: cnt <= 0, idx <= 0, go to RELEASE.
- RELEASE (one cycle): stage_rst[idx] <= 0, cnt <= 0, go to WAIT_ACK.
- WAIT_ACK:
  - Only stage_ack[idx] is sampled.
  - When it is high: cnt <= 0 and go to GAP. If the ack is already high on entry, it is accepted on the first WAIT_ACK cycle.
- GAP:
  - cnt increments.
  - When cnt == GAP_CYCLES-1: if idx == NUM_STAGES-1, go to DONE and set done <= 1; otherwise idx <= idx+1 and go to RELEASE.
- DONE: holds until rst_req or rst_n.
- Latency: stage_rst[0] falls HOLD_CYCLES+1 rising edges after the first edge that samples rst_req = 0 in HOLD.
- Stage spacing: with acks already high, stage_rst[k+1] falls GAP_CYCLES+2 edges after stage_rst[k].
- Released stages stay released. A stage_ack that drops after acceptance is ignored.
- rst_req = 1 in any state has priority over all other transitions. On the next edge:
  - stage_rst <= all ones; done <= 0; fault <= 0; fault_stage <= 0.
  - cnt <= 0; idx <= 0; state <= HOLD.
- rst_req held high keeps cnt at 0, so the hold count restarts on every request pulse.
- rst_n assertion mid-sequence forces the reset values immediately, without waiting for a clock edge.
- idx never exceeds NUM_STAGES-1.
- With NUM_STAGES = 1, the block goes from GAP directly to DONE.

Optional Feature:
- Macro: RESET_SEQUENCER_TIMEOUT_EN.
- Defined:
  - In WAIT_ACK, cnt increments each cycle without ack.
  - If the ack has not arrived when cnt == TIMEOUT_CYCLES-1, then on that edge: state <= FAULT, fault <= 1, fault_stage <= idx, stage_rst <= all ones.
  - An ack arriving on that same cycle wins: go to GAP, no fault.
  - FAULT is left only via rst_req or rst_n.
- Undefined:
  - WAIT_ACK waits indefinitely and FAULT is unreachable.
  - fault and fault_stage are tied to 0.
  - The TIMEOUT_CYCLES parameter is ignored.

Test Plan:
- Defaults, acks tied high, rst_req low after rst_n release -> stage_rst[0] falls at edge 17; stages 1..3 fall at edges 27, 37, 47; done rises at edge 56 (one GAP after stage 3 falls).
- rst_req pulsed high for 1 cycle at cnt = 10 in HOLD -> cnt restarts; stage_rst[0] falls 17 edges after rst_req returns low.
- stage_ack[1] held low for 200 cycles -> stage_rst[2..3] stay 1 and done = 0; after ack rises, stage_rst[2] falls GAP_CYCLES+2 edges later.
- rst_req asserted in DONE -> next edge stage_rst = 4'b1111 and done = 0; the full sequence repeats.
- rst_n asserted mid-GAP of stage 2 -> outputs are at reset values before the next clk edge.
- TIMEOUT_EN defined, TIMEOUT_CYCLES = 32, stage_ack[2] never rises -> 32 cycles after stage_rst[2] falls, fault = 1, fault_stage = 2, stage_rst = 4'b1111; rst_req pulse clears fault.
